// File: rtl/wb_pkg.sv
// Shared writeback encodings: mux-select codes, scheduler states and the
// load-use hazard test used by the issue stall logic.
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_e;

    // x0 is hardwired to zero, so a pending load to x0 never blocks issue.
    function automatic logic load_hazard(input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic [4:0] rd,
                                         input logic [4:0] ld_rd);
        return (ld_rd != 5'd0) && ((rs1 == ld_rd) || (rs2 == ld_rd) || (rd == ld_rd));
    endfunction

endpackage

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates the register-file write port between the
// in-order pipeline and one outstanding load, with a scoreboard and watchdog.
module wb_sched
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [1:0] issue_mtr,
    input  logic [4:0] issue_rd,
    input  logic [4:0] issue_rs1,
    input  logic [4:0] issue_rs2,
    output logic       issue_ready,
    input  logic       wb_valid,
    input  logic [1:0] wb_mtr,
    input  logic [4:0] wb_rd,
    output logic       wb_ready,
    input  logic       mem_rvalid,
    output logic [1:0] mtr,
    output logic       rf_we,
    output logic [4:0] rf_rd,
    output logic       load_busy,
    output logic       ld_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e        state, state_nxt;
    logic [4:0]       ld_rd, ld_rd_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_set;
    logic             done;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WB_IDLE;
            ld_rd      <= '0;
            cnt        <= '0;
            ld_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            ld_rd <= ld_rd_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) begin
                ld_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ld_rd_nxt   = ld_rd;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        issue_ready = 1'b0;
        wb_ready    = 1'b0;
        mtr         = WB_ALU;
        rf_we       = 1'b0;
        rf_rd       = '0;

        if (!rst) begin
            done = (state == WB_LOAD_WAIT) && mem_rvalid;

            // The completing load frees the scoreboard in the same cycle.
            if ((state == WB_IDLE) || done) begin
                issue_ready = 1'b1;
            end else begin
                issue_ready = (issue_mtr != WB_MEM) &&
                              !load_hazard(issue_rs1, issue_rs2, issue_rd, ld_rd);
            end
            accept = issue_valid && issue_ready && (issue_mtr == WB_MEM);

            if (done) begin
                mtr   = WB_MEM;
                rf_rd = ld_rd;
                rf_we = (ld_rd != 5'd0);
            end else if (wb_valid) begin
                mtr      = (wb_mtr == WB_MEM) ? WB_ALU : wb_mtr;
                rf_rd    = wb_rd;
                rf_we    = (wb_rd != 5'd0);
                wb_ready = 1'b1;
            end else begin
                wb_ready = 1'b1;
            end

            if (accept) begin
                state_nxt = WB_LOAD_WAIT;
                ld_rd_nxt = issue_rd;
                cnt_nxt   = '0;
            end else if (done) begin
                state_nxt = WB_IDLE;
            end else if (state == WB_LOAD_WAIT) begin
                if (cnt == CNT_LAST) begin
                    state_nxt   = WB_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end
    end

    assign load_busy = (state == WB_LOAD_WAIT);

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the scheduler.
module tb_wb_sched;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [1:0] issue_mtr;
    logic [4:0] issue_rd, issue_rs1, issue_rs2;
    logic       issue_ready;
    logic       wb_valid;
    logic [1:0] wb_mtr;
    logic [4:0] wb_rd;
    logic       wb_ready;
    logic       mem_rvalid;
    logic [1:0] mtr;
    logic       rf_we;
    logic [4:0] rf_rd;
    logic       load_busy;
    logic       ld_timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_sched #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_mtr(issue_mtr), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_mtr(wb_mtr), .wb_rd(wb_rd), .wb_ready(wb_ready),
        .mem_rvalid(mem_rvalid), .mtr(mtr), .rf_we(rf_we), .rf_rd(rf_rd),
        .load_busy(load_busy), .ld_timeout(ld_timeout)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_mtr = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        wb_valid = 0; wb_mtr = 0; wb_rd = 0; mem_rvalid = 0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = 1; issue_mtr = m; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    task automatic test_reset();
        rst = 1;
        issue(2'b01, 5'd3, 5'd1, 5'd2);
        wb_valid = 1; wb_mtr = 2'b10; wb_rd = 5'd4; mem_rvalid = 1;
        tick(); tick(); settle();
        vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL rst_issue_ready got=%b exp=0", issue_ready); end
        vectors++; if (wb_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wb_ready got=%b exp=0", wb_ready); end
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rst_rf_we got=%b exp=0", rf_we); end
        vectors++; if (mtr !== 2'b00) begin miscompares++; $display("FAIL rst_mtr got=%b exp=00", mtr); end
        vectors++; if (rf_rd !== 5'd0) begin miscompares++; $display("FAIL rst_rf_rd got=%0d exp=0", rf_rd); end
        tick(); rst = 0; idle_inputs(); settle();
        vectors++; if (load_busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_load_busy got=%b exp=0", load_busy); end
        vectors++; if (ld_timeout !== 1'b0) begin miscompares++; $display("FAIL post_rst_ld_timeout got=%b exp=0", ld_timeout); end
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_issue_ready got=%b exp=1", issue_ready); end
        vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_wb_ready got=%b exp=1", wb_ready); end
    endtask

    task automatic test_alu_wb();
        logic [1:0] src [3];
        logic [1:0] exp_m [3];
        logic [4:0] dst [3];
        src = '{2'b00, 2'b11, 2'b01};
        exp_m = '{2'b00, 2'b11, 2'b00};
        dst = '{5'd5, 5'd9, 5'd17};
        for (int i = 0; i < 3; i++) begin
            tick(); idle_inputs();
            wb_valid = 1; wb_mtr = src[i]; wb_rd = dst[i];
            settle();
            vectors++; if (mtr !== exp_m[i] || rf_we !== 1'b1 || rf_rd !== dst[i] || wb_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL alu_wb[%0d] got mtr=%b we=%b rd=%0d rdy=%b exp mtr=%b we=1 rd=%0d rdy=1",
                         i, mtr, rf_we, rf_rd, wb_ready, exp_m[i], dst[i]);
            end
        end
        tick(); idle_inputs(); settle();
        vectors++; if (rf_we !== 1'b0 || wb_ready !== 1'b1 || mtr !== 2'b00) begin
            miscompares++; $display("FAIL no_wb got we=%b rdy=%b mtr=%b exp we=0 rdy=1 mtr=00", rf_we, wb_ready, mtr);
        end
    endtask

    task automatic test_load_dependent();
        tick(); idle_inputs(); issue(2'b01, 5'd7, 5'd1, 5'd2); settle();
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL ld_accept got=%b exp=1", issue_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(); idle_inputs(); issue(2'b00, 5'd2, 5'd7, 5'd0); settle();
            vectors++; if (issue_ready !== 1'b0 || load_busy !== 1'b1) begin
                miscompares++; $display("FAIL dep_stall[%0d] got rdy=%b busy=%b exp rdy=0 busy=1", i, issue_ready, load_busy);
            end
        end
        tick(); mem_rvalid = 1; settle();
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL dep_release got=%b exp=1", issue_ready); end
        vectors++; if (mtr !== 2'b01 || rf_rd !== 5'd7 || rf_we !== 1'b1 || wb_ready !== 1'b0) begin
            miscompares++; $display("FAIL ld_write got mtr=%b rd=%0d we=%b rdy=%b exp mtr=01 rd=7 we=1 rdy=0", mtr, rf_rd, rf_we, wb_ready);
        end
        tick(); idle_inputs(); settle();
        vectors++; if (load_busy !== 1'b0) begin miscompares++; $display("FAIL ld_done_busy got=%b exp=0", load_busy); end
    endtask

    task automatic test_collision();
        tick(); idle_inputs(); issue(2'b01, 5'd12, 5'd0, 5'd0); settle();
        tick(); idle_inputs(); mem_rvalid = 1; wb_valid = 1; wb_mtr = 2'b10; wb_rd = 5'd3; settle();
        vectors++; if (mtr !== 2'b01 || rf_rd !== 5'd12 || rf_we !== 1'b1 || wb_ready !== 1'b0) begin
            miscompares++; $display("FAIL coll_load got mtr=%b rd=%0d we=%b rdy=%b exp mtr=01 rd=12 we=1 rdy=0", mtr, rf_rd, rf_we, wb_ready);
        end
        tick(); mem_rvalid = 0; settle();
        vectors++; if (mtr !== 2'b10 || rf_rd !== 5'd3 || rf_we !== 1'b1 || wb_ready !== 1'b1) begin
            miscompares++; $display("FAIL coll_wb got mtr=%b rd=%0d we=%b rdy=%b exp mtr=10 rd=3 we=1 rdy=1", mtr, rf_rd, rf_we, wb_ready);
        end
    endtask

    task automatic test_x0();
        tick(); idle_inputs(); issue(2'b01, 5'd0, 5'd4, 5'd4); settle();
        tick(); idle_inputs(); issue(2'b00, 5'd0, 5'd0, 5'd0); settle();
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL x0_no_hazard got=%b exp=1", issue_ready); end
        tick(); idle_inputs(); mem_rvalid = 1; settle();
        vectors++; if (rf_we !== 1'b0 || mtr !== 2'b01) begin
            miscompares++; $display("FAIL x0_load_we got we=%b mtr=%b exp we=0 mtr=01", rf_we, mtr);
        end
    endtask

    task automatic test_back_to_back();
        tick(); idle_inputs(); issue(2'b01, 5'd4, 5'd0, 5'd0); settle();
        tick(); idle_inputs(); mem_rvalid = 1; issue(2'b01, 5'd6, 5'd0, 5'd0); settle();
        vectors++; if (issue_ready !== 1'b1 || rf_rd !== 5'd4 || rf_we !== 1'b1) begin
            miscompares++; $display("FAIL b2b_first got rdy=%b rd=%0d we=%b exp rdy=1 rd=4 we=1", issue_ready, rf_rd, rf_we);
        end
        tick(); idle_inputs(); issue(2'b00, 5'd1, 5'd2, 5'd6); settle();
        vectors++; if (load_busy !== 1'b1 || issue_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_busy got busy=%b rdy=%b exp busy=1 rdy=0", load_busy, issue_ready);
        end
        issue(2'b01, 5'd9, 5'd1, 5'd2); #0;
        vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_second_load got=%b exp=0", issue_ready); end
        tick(); idle_inputs(); mem_rvalid = 1; settle();
        vectors++; if (rf_rd !== 5'd6 || rf_we !== 1'b1) begin
            miscompares++; $display("FAIL b2b_second_write got rd=%0d we=%b exp rd=6 we=1", rf_rd, rf_we);
        end
        tick(); idle_inputs(); settle();
        vectors++; if (load_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy got=%b exp=0", load_busy); end
    endtask

    task automatic test_timeout();
        tick(); idle_inputs(); issue(2'b01, 5'd9, 5'd0, 5'd0); settle();
        for (int k = 1; k <= TO; k++) begin
            tick(); idle_inputs(); settle();
            vectors++; if (load_busy !== 1'b1 || ld_timeout !== 1'b0) begin
                miscompares++; $display("FAIL wdog_wait[%0d] got busy=%b to=%b exp busy=1 to=0", k, load_busy, ld_timeout);
            end
        end
        tick(); settle();
        vectors++; if (ld_timeout !== 1'b1 || load_busy !== 1'b0) begin
            miscompares++; $display("FAIL wdog_fire got to=%b busy=%b exp to=1 busy=0", ld_timeout, load_busy);
        end
        tick(); mem_rvalid = 1; settle();
        vectors++; if (rf_we !== 1'b0 || mtr !== 2'b00) begin
            miscompares++; $display("FAIL late_rvalid got we=%b mtr=%b exp we=0 mtr=00", rf_we, mtr);
        end
        tick(); idle_inputs(); settle();
        vectors++; if (ld_timeout !== 1'b1) begin miscompares++; $display("FAIL wdog_sticky got=%b exp=1", ld_timeout); end
    endtask

    task automatic test_reset_mid_load();
        tick(); idle_inputs(); issue(2'b01, 5'd10, 5'd0, 5'd0); settle();
        tick(); idle_inputs(); settle();
        vectors++; if (load_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy got=%b exp=1", load_busy); end
        tick(); rst = 1; wb_valid = 1; wb_rd = 5'd8; mem_rvalid = 1; settle();
        vectors++; if (issue_ready !== 1'b0 || wb_ready !== 1'b0 || rf_we !== 1'b0 || mtr !== 2'b00 || rf_rd !== 5'd0) begin
            miscompares++; $display("FAIL midrst_outputs got rdy=%b wbr=%b we=%b mtr=%b rd=%0d exp all 0",
                                    issue_ready, wb_ready, rf_we, mtr, rf_rd);
        end
        tick(); rst = 0; idle_inputs(); mem_rvalid = 1; settle();
        vectors++; if (ld_timeout !== 1'b0 || load_busy !== 1'b0 || rf_we !== 1'b0) begin
            miscompares++; $display("FAIL midrst_after got to=%b busy=%b we=%b exp 0 0 0", ld_timeout, load_busy, rf_we);
        end
    endtask

    // Model: a pending load is just "which register, how long we've waited".
    task automatic test_random();
        bit   busy = 0, tmo = 0, hold = 0;
        int   ldrd = 0, age = 0, m;
        bit   done, e_ir, e_wbr, e_we;
        int   e_mtr, e_rd;
        tick(); idle_inputs(); rst = 1; settle();
        for (int i = 0; i < 400; i++) begin
            tick();
            rst = ($urandom_range(0, 49) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_mtr = 2'($urandom_range(0, 3));
            issue_rd  = 5'($urandom_range(0, 7));
            issue_rs1 = 5'($urandom_range(0, 7));
            issue_rs2 = 5'($urandom_range(0, 7));
            if (!hold) begin
                wb_valid = $urandom_range(0, 1);
                m = $urandom_range(0, 2);
                wb_mtr = (m == 0) ? 2'b00 : (m == 1) ? 2'b10 : 2'b11;
                wb_rd = 5'($urandom_range(0, 7));
            end
            mem_rvalid = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            settle();

            done = 0; e_ir = 0; e_wbr = 0; e_we = 0; e_mtr = 0; e_rd = 0;
            if (!rst) begin
                done = busy && mem_rvalid;
                if (!busy || done) e_ir = 1;
                else e_ir = (issue_mtr != 2'b01) &&
                            !(ldrd != 0 && (issue_rs1 == ldrd || issue_rs2 == ldrd || issue_rd == ldrd));
                if (done) begin
                    e_mtr = 1; e_rd = ldrd; e_we = (ldrd != 0);
                end else if (wb_valid) begin
                    e_mtr = wb_mtr; e_rd = wb_rd; e_we = (wb_rd != 0); e_wbr = 1;
                end else begin
                    e_wbr = 1;
                end
            end

            vectors++; if (issue_ready !== e_ir) begin miscompares++; $display("FAIL rnd_issue_ready cyc=%0d got=%b exp=%b", i, issue_ready, e_ir); end
            vectors++; if (wb_ready !== e_wbr) begin miscompares++; $display("FAIL rnd_wb_ready cyc=%0d got=%b exp=%b", i, wb_ready, e_wbr); end
            vectors++; if (mtr !== 2'(e_mtr)) begin miscompares++; $display("FAIL rnd_mtr cyc=%0d got=%b exp=%0d", i, mtr, e_mtr); end
            vectors++; if (rf_we !== e_we) begin miscompares++; $display("FAIL rnd_rf_we cyc=%0d got=%b exp=%b", i, rf_we, e_we); end
            vectors++; if (rf_rd !== 5'(e_rd)) begin miscompares++; $display("FAIL rnd_rf_rd cyc=%0d got=%0d exp=%0d", i, rf_rd, e_rd); end
            vectors++; if (load_busy !== busy) begin miscompares++; $display("FAIL rnd_load_busy cyc=%0d got=%b exp=%b", i, load_busy, busy); end
            vectors++; if (ld_timeout !== tmo) begin miscompares++; $display("FAIL rnd_ld_timeout cyc=%0d got=%b exp=%b", i, ld_timeout, tmo); end

            hold = !rst && wb_valid && !e_wbr;
            if (rst) begin
                busy = 0; ldrd = 0; age = 0; tmo = 0;
            end else if (issue_valid && e_ir && issue_mtr == 2'b01) begin
                busy = 1; ldrd = issue_rd; age = 0;
            end else if (done) begin
                busy = 0;
            end else if (busy) begin
                age++;
                if (age == TO) begin busy = 0; tmo = 1; end
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_alu_wb();
        test_load_dependent();
        test_collision();
        test_x0();
        test_back_to_back();
        test_timeout();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_sched.md
# wb_sched

Writeback scheduler for the single-port register file. Sequences the select of the writeback mux (ALU / data memory / pc+4 / immediate), and arbitrates the write port between the in-order pipeline writeback and one outstanding variable-latency data-memory load. Holds a one-entry load scoreboard that stalls dependent issue. Includes a load watchdog. Sits between the decode/issue stage, the writeback stage, the data-memory response and the register-file write port.

## Interface
- TIMEOUT, 255: LOAD_WAIT cycles without a response before the load is abandoned (1..2^CNT_W-1).
- CNT_W, 8: watchdog counter width.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction presented at issue
- issue_mtr  in  2  writeback source of that instruction (00 ALU, 01 load, 10 pc4, 11 imm)
- issue_rd  in  5  destination register
- issue_rs1, issue_rs2  in  5 each  source registers
- issue_ready  out  1  instruction may issue this cycle
- wb_valid  in  1  pipeline writeback stage holds a non-load result
- wb_mtr  in  2  its source (00, 10 or 11; 01 illegal)
- wb_rd  in  5  its destination
- wb_ready  out  1  pipeline result written this cycle
- mem_rvalid  in  1  data-memory load data valid this cycle
- mtr  out  2  writeback mux select
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- load_busy  out  1  state is LOAD_WAIT
- ld_timeout  out  1  sticky watchdog error

## Operation
- States:
  - IDLE.
  - LOAD_WAIT: holds ld_rd (registered) and watchdog count cnt.
- IDLE:
  - issue_ready=1.
  - An issue with issue_valid&&issue_ready&&issue_mtr==01 latches ld_rd=issue_rd and cnt=0, then moves to LOAD_WAIT.
- LOAD_WAIT, without mem_rvalid, issue_ready=0 when any of the following holds:
  - issue_mtr==01 (one load outstanding max);
  - ld_rd!=0 and (issue_rs1==ld_rd or issue_rs2==ld_rd or issue_rd==ld_rd).
  - Otherwise issue_ready=1.
- LOAD_WAIT with mem_rvalid (completion cycle):
  - Scoreboard clears this cycle, so issue_ready follows the IDLE rule.
  - A load accepted this cycle re-enters LOAD_WAIT with the new ld_rd and cnt=0.
  - Otherwise the state returns to IDLE.
- Write-port arbitration, priority high to low:
  1. LOAD_WAIT && mem_rvalid: mtr=01, rf_rd=ld_rd, rf_we=(ld_rd!=0), wb_ready=0.
  2. wb_valid: mtr=wb_mtr, rf_rd=wb_rd, rf_we=(wb_rd!=0), wb_ready=1.
  3. Otherwise: mtr=00, rf_rd=0, rf_we=0, wb_ready=1.
- Register x0 is never written and never causes a hazard.
- Watchdog:
  - cnt increments each LOAD_WAIT cycle without mem_rvalid.
  - When cnt==TIMEOUT-1 and mem_rvalid=0, the next state is IDLE, ld_timeout is set to 1, and there is no write.
  - ld_timeout is cleared only by rst.
- mem_rvalid in IDLE (spurious): ignored, no write.
- wb_valid with wb_mtr==01: treated as 00 (no assertion required in RTL; the bench flags it).

## Timing
- Outputs mtr, rf_we, rf_rd, wb_ready and issue_ready are combinational from state, ld_rd and the inputs. load_busy and ld_timeout are registered.
- While rst=1:
  - issue_ready=0, wb_ready=0, rf_we=0, mtr=00, rf_rd=0.
- First cycle after rst deasserts: state IDLE, cnt=0, ld_rd=0, load_busy=0, ld_timeout=0.
- Load latency:
  - Load accepted at edge N: load_busy=1 from cycle N+1.
  - Earliest mem_rvalid is cycle N+1.
  - The write occurs in the mem_rvalid cycle, and load_busy=0 on the following cycle unless a new load was accepted.
- A pipeline result blocked by a load write stalls exactly the cycles mem_rvalid is high in LOAD_WAIT. It is written the next free cycle, with inputs held by the pipeline.
- Timeout: with no response, ld_timeout=1 and load_busy=0 in cycle N+1+TIMEOUT.
- rst mid-load: the load is dropped, and a later mem_rvalid is ignored as spurious.

## Structure
- Shared package wb_pkg:
  - mtr encodings WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11;
  - state encoding WB_IDLE=1'b0, WB_LOAD_WAIT=1'b1.
- No sub-module. The watchdog counter and scoreboard are inline.
- The wb_mux instance stays in the core top level, driven by mtr.

## Test plan
- ALU writeback: wb_valid=1, wb_mtr=00, wb_rd=5 in IDLE -> mtr=00, rf_we=1, rf_rd=5, wb_ready=1.
- Load then dependent issue:
  - Stimulus: load rd=7 issued; next cycle issue rs1=7; mem_rvalid arrives 3 cycles later.
  - Response: issue_ready=0 for 3 cycles, then 1 in the mem_rvalid cycle; that cycle has mtr=01, rf_rd=7, rf_we=1.
- Collision: mem_rvalid and wb_valid (wb_rd=3, mtr=10) in the same cycle -> load written, wb_ready=0; next cycle mtr=10, rf_rd=3, wb_ready=1.
- x0 cases:
  - Load rd=0 completing -> rf_we=0.
  - Issue rs1=0 during LOAD_WAIT with ld_rd=0 -> issue_ready=1.
- Timeout: TIMEOUT=4, load issued and no response -> ld_timeout=1 and load_busy=0 at cycle N+5; a later mem_rvalid produces no write.
- Back-to-back loads plus reset: second load issued in the completion cycle of the first -> accepted and load_busy stays 1. Asserting rst mid-load -> all outputs at reset values; ld_timeout=0.
